router_sync_np: RTL and testbench
=================================

Name: router_sync_np

Overview:
- Parametrised successor to the three-port router synchroniser.
- Latches the destination address of each packet and decodes the FIFO write enables for that destination.
- Muxes back the selected FIFO's full flag and drives per-port valid_out.
- Runs an independent read-timeout watchdog per output port that issues a one-cycle soft reset to a FIFO left unread.
- New relative to the fixed three-port block:
  - N ports.
  - Programmable timeout.
  - Registered invalid-address error flag.
  - Sticky per-port timeout status with clear.

Parameters:
- N_PORTS, 3, number of output FIFOs/ports; legal range 2..16.
- ADDR_W, 2, width of d_in and of the address register; must satisfy 2**ADDR_W >= N_PORTS.
- TIMEOUT, 30, consecutive unread-valid cycles before a soft reset; legal range 2..1024.
- CNT_W, 5, watchdog counter width; must satisfy 2**CNT_W >= TIMEOUT.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-low reset.
- detect_add  in  1  high on the header cycle; loads d_in into the address register.
- write_enb_reg  in  1  FSM request to write the current byte to the addressed FIFO.
- d_in  in  ADDR_W  destination address field of the header.
- read  in  N_PORTS  per-port read strobe from the downstream consumer.
- empty  in  N_PORTS  per-port FIFO empty flags.
- full  in  N_PORTS  per-port FIFO full flags.
- clr_status  in  1  synchronous clear of all timeout_sticky bits.
- write_enb  out  N_PORTS  one-hot FIFO write enable (combinational).
- valid_out  out  N_PORTS  per-port data-available flag (combinational).
- fifo_full  out  1  full flag of the addressed FIFO (combinational).
- soft_reset  out  N_PORTS  per-port one-cycle FIFO soft-reset pulse (registered).
- addr_err  out  1  latched address is out of range (registered).
- timeout_sticky  out  N_PORTS  per-port sticky watchdog-fired status (registered).

Behaviour:

Reset (rst low, asynchronous, takes effect immediately):
- Address register = 0.
- addr_err = 0.
- All counters = 0.
- soft_reset = 0.
- timeout_sticky = 0.
- While rst is low the combinational outputs follow from address 0: write_enb = 0 unless write_enb_reg is high, in which case write_enb[0] = 1; fifo_full = full[0].

Address latch:
- On a clk edge with detect_add = 1: address register <= d_in, and addr_err <= (d_in >= N_PORTS).
- Otherwise both hold.
- Latency is one cycle: decode uses the new address from the cycle after detect_add.

Write enable decode (combinational):
- write_enb[i] = write_enb_reg and (addr == i) and !addr_err.
- An out-of-range address gives all-zero write_enb.

fifo_full (combinational):
- fifo_full = full[addr] when !addr_err; 0 when addr_err.

valid_out (combinational):
- valid_out[i] = !empty[i].

Watchdog, identical and independent per port i, evaluated at each clk edge:
- If valid_out[i] = 0 or read[i] = 1: cnt_i <= 0, soft_reset[i] <= 0.
- Else, if cnt_i == TIMEOUT-1: cnt_i <= 0, soft_reset[i] <= 1.
- Else: cnt_i <= cnt_i+1, soft_reset[i] <= 0.
- soft_reset[i] therefore rises after the TIMEOUT-th consecutive edge sampling valid and !read, and lasts exactly one cycle.
- If the condition persists, the port fires again every TIMEOUT cycles.
- Any read or empty cycle restarts the count from 0.
- A read in the same cycle the count would hit TIMEOUT-1 suppresses the pulse.
- Ports never share a counter; activity on port j has no effect on port i.

Sticky status:
- timeout_sticky[i] <= 1 on any edge where soft_reset[i] is being set to 1.
- All bits clear to 0 on an edge with clr_status = 1.
- If set and clear occur together, set wins for that port.

General:
- No internal state other than the address register, addr_err, counters, soft_reset and timeout_sticky.
- Counter arithmetic is unsigned CNT_W; wrap past TIMEOUT-1 cannot occur.

Test Plan:
- Reset defaults: hold rst low mid-run with counters non-zero, soft_reset and timeout_sticky set → all registers 0 immediately, with no clk edge needed; write_enb_reg=1 → write_enb = 0...01.
- Decode, N_PORTS=3: detect_add with d_in=2, then write_enb_reg=1 → write_enb=3'b100 from the next cycle; full=3'b100 → fifo_full=1. d_in=3 → addr_err=1, write_enb=0, fifo_full=0.
- Timeout, TIMEOUT=30: empty[1]=0 and read[1]=0 held → soft_reset[1] high for exactly one cycle after the 30th edge, again after the 60th; timeout_sticky[1]=1; ports 0 and 2 stay 0.
- Restart: idle for 29 edges, read[1]=1 on the 30th → no pulse; 30 further idle edges needed before the next pulse. empty[1]=1 mid-count also restarts the count.
- Sticky clear: clr_status pulsed on the same edge soft_reset[0] fires → timeout_sticky[0] stays 1; on a later clr_status → 0.
- Scaling: N_PORTS=8, ADDR_W=3, TIMEOUT=5 → every address 0..7 yields the correct one-hot write_enb; concurrent timeouts on ports 3 and 7 pulse independently after 5 edges.

Source files
------------

// File: rtl/router_sync_np_if.sv
// Bundle of header-decode, FIFO status and watchdog signals for router_sync_np.
// Latency: none; this is a plain signal bundle with no logic inside.
// Backpressure: none; the addressed FIFO's full flag is returned on fifo_full.
//
// Ports (signals):
//   master drives detect_add, write_enb_reg, d_in, read, empty, full, clr_status
//   slave  drives write_enb, valid_out, fifo_full, soft_reset, addr_err, timeout_sticky
interface router_sync_np_if #(
   parameter int N_PORTS = 3,
   parameter int ADDR_W  = 2
);
   logic                detect_add;
   logic                write_enb_reg;
   logic [ADDR_W-1:0]   d_in;
   logic [N_PORTS-1:0]  read;
   logic [N_PORTS-1:0]  empty;
   logic [N_PORTS-1:0]  full;
   logic                clr_status;

   logic [N_PORTS-1:0]  write_enb;
   logic [N_PORTS-1:0]  valid_out;
   logic                fifo_full;
   logic [N_PORTS-1:0]  soft_reset;
   logic                addr_err;
   logic [N_PORTS-1:0]  timeout_sticky;

   modport master (
      output detect_add, write_enb_reg, d_in, read, empty, full, clr_status,
      input  write_enb, valid_out, fifo_full, soft_reset, addr_err, timeout_sticky
   );

   modport slave (
      input  detect_add, write_enb_reg, d_in, read, empty, full, clr_status,
      output write_enb, valid_out, fifo_full, soft_reset, addr_err, timeout_sticky
   );
endinterface

// File: rtl/router_sync_np.sv
// N-port router synchroniser: latches destination, decodes FIFO write enables, read-timeout watchdog.
// Latency: address/addr_err one cycle after detect_add; write_enb/valid_out/fifo_full combinational; soft_reset registered.
// Backpressure: none internally; the addressed FIFO's full flag is muxed back on fifo_full for the writer FSM.
//
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-low reset
//   bus  - router_sync_np_if.slave: header/write request, per-port read/empty/full, clr_status in;
//          write_enb, valid_out, fifo_full, soft_reset, addr_err, timeout_sticky out
module router_sync_np #(
   parameter int N_PORTS = 3,
   parameter int ADDR_W  = 2,
   parameter int TIMEOUT = 30,
   parameter int CNT_W   = 5
) (
   input  logic               clk,
   input  logic               rst,
   router_sync_np_if.slave    bus
);

   // Last count value before the watchdog fires.
   localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(TIMEOUT - 1);
   // Port count in address width + 1 so every d_in value compares cleanly.
   localparam logic [ADDR_W:0]  N_PORTS_A = (ADDR_W + 1)'(N_PORTS);

   logic [ADDR_W-1:0]             addr_q, addr_d;
   logic                          addr_err_q, addr_err_d;
   logic [N_PORTS-1:0][CNT_W-1:0] cnt_q, cnt_d;
   logic [N_PORTS-1:0]            soft_reset_q, soft_reset_d;
   logic [N_PORTS-1:0]            timeout_sticky_q, timeout_sticky_d;

   logic [N_PORTS-1:0]            valid;
   logic [N_PORTS-1:0]            write_enb;
   logic                          fifo_full;

   assign valid = ~bus.empty;

   // Address latch: the range check is taken from d_in itself so the error
   // flag is aligned with the address it describes.
   always_comb begin
      addr_d     = addr_q;
      addr_err_d = addr_err_q;
      if (bus.detect_add) begin
         addr_d     = bus.d_in;
         addr_err_d = ({1'b0, bus.d_in} >= N_PORTS_A);
      end
   end

   // Per-port watchdog. The counter returns to zero on the firing edge, so a
   // persistently unread port fires again every TIMEOUT cycles.
   always_comb begin
      cnt_d        = cnt_q;
      soft_reset_d = '0;
      for (int i = 0; i < N_PORTS; i++) begin
         if (!valid[i] || bus.read[i]) begin
            cnt_d[i]        = '0;
            soft_reset_d[i] = 1'b0;
         end else if (cnt_q[i] == CNT_TOP) begin
            cnt_d[i]        = '0;
            soft_reset_d[i] = 1'b1;
         end else begin
            cnt_d[i]        = cnt_q[i] + CNT_W'(1);
            soft_reset_d[i] = 1'b0;
         end
      end
   end

   // A watchdog firing on the same edge as a clear keeps its bit set.
   always_comb begin
      timeout_sticky_d = (bus.clr_status ? '0 : timeout_sticky_q) | soft_reset_d;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         addr_q           <= '0;
         addr_err_q       <= 1'b0;
         cnt_q            <= '0;
         soft_reset_q     <= '0;
         timeout_sticky_q <= '0;
      end else begin
         addr_q           <= addr_d;
         addr_err_q       <= addr_err_d;
         cnt_q            <= cnt_d;
         soft_reset_q     <= soft_reset_d;
         timeout_sticky_q <= timeout_sticky_d;
      end
   end

   // Decode by comparison rather than indexing so an out-of-range address
   // never selects a nonexistent port; addr_err forces everything off.
   always_comb begin
      write_enb = '0;
      fifo_full = 1'b0;
      for (int i = 0; i < N_PORTS; i++) begin
         if (!addr_err_q && (addr_q == ADDR_W'(i))) begin
            write_enb[i] = bus.write_enb_reg;
            fifo_full    = bus.full[i];
         end
      end
   end

   assign bus.write_enb      = write_enb;
   assign bus.valid_out      = valid;
   assign bus.fifo_full      = fifo_full;
   assign bus.soft_reset     = soft_reset_q;
   assign bus.addr_err       = addr_err_q;
   assign bus.timeout_sticky = timeout_sticky_q;

endmodule

// File: tb/tb_router_sync_np.sv
// Randomised scoreboard bench for router_sync_np: two instances (3 ports / timeout 30, 8 ports / timeout 5).
// Latency: expectations pushed each cycle from a run-length reference model; monitor compares after the push.
// Backpressure: none; the monitor drains the scoreboard queue on every check event.
module tb_router_sync_np;

   logic clk = 1'b0;
   logic rst;
   always #10 clk = ~clk;

   router_sync_np_if #(.N_PORTS(3), .ADDR_W(2)) ifa ();
   router_sync_np_if #(.N_PORTS(8), .ADDR_W(3)) ifb ();

   router_sync_np #(.N_PORTS(3), .ADDR_W(2), .TIMEOUT(30), .CNT_W(5)) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (ifa)
   );

   router_sync_np #(.N_PORTS(8), .ADDR_W(3), .TIMEOUT(5), .CNT_W(3)) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (ifb)
   );

   // ---------------- reference model ----------------
   int n_p [2] = '{3, 8};
   int t_o [2] = '{30, 5};

   int m_addr   [2];
   int m_run    [2][8];   // consecutive edges seen valid and unread
   bit m_sr     [2][8];
   bit m_sticky [2][8];

   int rprof [2][8];
   int eprof [2][8];

   typedef struct {
      int d;
      int we;
      int vo;
      int ff;
      int sr;
      int ae;
      int st;
   } exp_t;

   exp_t sb [$];
   event chk_ev;

   int vectors     = 0;
   int miscompares = 0;

   function automatic void get_in(input int d, output logic det, output logic web,
                                  output logic clr, output int din, output logic [15:0] rd,
                                  output logic [15:0] em, output logic [15:0] fu);
      if (d == 0) begin
         det = ifa.detect_add; web = ifa.write_enb_reg; clr = ifa.clr_status;
         din = int'(ifa.d_in);
         rd = 16'(ifa.read); em = 16'(ifa.empty); fu = 16'(ifa.full);
      end else begin
         det = ifb.detect_add; web = ifb.write_enb_reg; clr = ifb.clr_status;
         din = int'(ifb.d_in);
         rd = 16'(ifb.read); em = 16'(ifb.empty); fu = 16'(ifb.full);
      end
   endfunction

   function automatic void model_reset();
      for (int d = 0; d < 2; d++) begin
         m_addr[d] = 0;
         for (int i = 0; i < 8; i++) begin
            m_run[d][i] = 0; m_sr[d][i] = 0; m_sticky[d][i] = 0;
         end
      end
   endfunction

   // One clock edge of the specified behaviour, in terms of idle run lengths.
   function automatic void model_step(input int d);
      logic det, web, clr;
      int din;
      logic [15:0] rd, em, fu;
      get_in(d, det, web, clr, din, rd, em, fu);
      for (int i = 0; i < n_p[d]; i++) begin
         if (!em[i] && !rd[i]) begin
            m_run[d][i]++;
            m_sr[d][i] = (m_run[d][i] % t_o[d]) == 0;
         end else begin
            m_run[d][i] = 0;
            m_sr[d][i]  = 0;
         end
         if (m_sr[d][i])  m_sticky[d][i] = 1;
         else if (clr)    m_sticky[d][i] = 0;
      end
      if (det) m_addr[d] = din;
   endfunction

   function automatic exp_t expect_now(input int d);
      exp_t e;
      logic det, web, clr;
      int din;
      logic [15:0] rd, em, fu;
      bit err;
      get_in(d, det, web, clr, din, rd, em, fu);
      err  = m_addr[d] >= n_p[d];
      e.d  = d;
      e.we = (web && !err) ? (1 << m_addr[d]) : 0;
      e.ff = err ? 0 : int'(fu[m_addr[d]]);
      e.vo = int'(~em) & ((1 << n_p[d]) - 1);
      e.ae = int'(err);
      e.sr = 0;
      e.st = 0;
      for (int i = 0; i < n_p[d]; i++) begin
         if (m_sr[d][i])     e.sr |= (1 << i);
         if (m_sticky[d][i]) e.st |= (1 << i);
      end
      return e;
   endfunction

   function automatic void push_both();
      sb.push_back(expect_now(0));
      sb.push_back(expect_now(1));
   endfunction

   // ---------------- stimulus ----------------
   function automatic logic pick_read(input int prof);
      case (prof)
         0:       return 1'b0;
         1:       return $urandom_range(63) == 0;
         default: return $urandom_range(2) == 0;
      endcase
   endfunction

   function automatic logic pick_empty(input int prof);
      case (prof)
         0:       return 1'b0;
         1:       return $urandom_range(7) == 0;
         default: return $urandom_range(1) == 0;
      endcase
   endfunction

   task automatic drive_rand(input int d);
      logic [15:0] rd, em, fu;
      logic det, web, clr;
      int din;
      rd = '0; em = '0; fu = 16'($urandom);
      for (int i = 0; i < 8; i++) begin
         rd[i] = pick_read(rprof[d][i]);
         em[i] = pick_empty(eprof[d][i]);
      end
      det = $urandom_range(5) == 0;
      web = $urandom_range(1) == 0;
      clr = (d == 0) ? ($urandom_range(39) == 0) : ($urandom_range(15) == 0);
      din = (d == 0) ? int'($urandom_range(3)) : int'($urandom_range(7));
      if (d == 0) begin
         ifa.detect_add = det; ifa.write_enb_reg = web; ifa.clr_status = clr;
         ifa.d_in = 2'(din); ifa.read = rd[2:0]; ifa.empty = em[2:0]; ifa.full = fu[2:0];
      end else begin
         ifb.detect_add = det; ifb.write_enb_reg = web; ifb.clr_status = clr;
         ifb.d_in = 3'(din); ifb.read = rd[7:0]; ifb.empty = em[7:0]; ifb.full = fu[7:0];
      end
   endtask

   task automatic zero_inputs();
      ifa.detect_add = 0; ifa.write_enb_reg = 0; ifa.clr_status = 0; ifa.d_in = '0;
      ifa.read = '0; ifa.empty = '1; ifa.full = '0;
      ifb.detect_add = 0; ifb.write_enb_reg = 0; ifb.clr_status = 0; ifb.d_in = '0;
      ifb.read = '0; ifb.empty = '1; ifb.full = '0;
   endtask

   initial begin
      rst = 1'b0;
      zero_inputs();
      model_reset();
      ifa.write_enb_reg = 1'b1;
      ifb.write_enb_reg = 1'b1;
      #3;
      push_both();
      -> chk_ev;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;

      for (int seg = 0; seg < 40; seg++) begin
         for (int d = 0; d < 2; d++)
            for (int i = 0; i < 8; i++) begin
               rprof[d][i] = (seg == 0) ? 0 : int'($urandom_range(2));
               eprof[d][i] = (seg == 0) ? 0 : int'($urandom_range(2));
            end
         for (int cyc = 0; cyc < 80; cyc++) begin
            @(posedge clk);
            model_step(0);
            model_step(1);
            #1;
            drive_rand(0);
            drive_rand(1);
            if (seg == 20 && cyc == 40) begin
               // Asynchronous reset between edges, with write requests pending.
               ifa.write_enb_reg = 1'b1;
               ifb.write_enb_reg = 1'b1;
               #1 rst = 1'b0;
               model_reset();
               #1;
               push_both();
               -> chk_ev;
               #3 rst = 1'b1;
            end
            @(negedge clk);
            push_both();
            -> chk_ev;
         end
      end
      #5;
      if (sb.size() != 0) begin
         miscompares++;
         $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   // ---------------- monitor ----------------
   task automatic chk(input string nm, input int d, input int act, input int exp_v);
      vectors++;
      if (act != exp_v) begin
         miscompares++;
         $display("FAIL %s dut%0d @%0t: got %0h, required %0h", nm, d, $time, act, exp_v);
      end
   endtask

   initial begin
      exp_t e;
      forever begin
         @(chk_ev);
         #1;
         while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.d == 0) begin
               chk("write_enb",      0, int'(ifa.write_enb),      e.we);
               chk("valid_out",      0, int'(ifa.valid_out),      e.vo);
               chk("fifo_full",      0, int'(ifa.fifo_full),      e.ff);
               chk("soft_reset",     0, int'(ifa.soft_reset),     e.sr);
               chk("addr_err",       0, int'(ifa.addr_err),       e.ae);
               chk("timeout_sticky", 0, int'(ifa.timeout_sticky), e.st);
            end else begin
               chk("write_enb",      1, int'(ifb.write_enb),      e.we);
               chk("valid_out",      1, int'(ifb.valid_out),      e.vo);
               chk("fifo_full",      1, int'(ifb.fifo_full),      e.ff);
               chk("soft_reset",     1, int'(ifb.soft_reset),     e.sr);
               chk("addr_err",       1, int'(ifb.addr_err),       e.ae);
               chk("timeout_sticky", 1, int'(ifb.timeout_sticky), e.st);
            end
         end
      end
   end

endmodule
